// File: rtl/hazard_run_ctrl.sv
// Hazard, forwarding and debug run-control for the 5-stage core.
// Optional stall performance counter: define HAZARD_PERF_CNT_EN.
module hazard_run_ctrl #(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       RsD,
   input  logic [4:0]       RtD,
   input  logic [4:0]       RsE,
   input  logic [4:0]       RtE,
   input  logic [4:0]       WriteRegE,
   input  logic [4:0]       WriteRegM,
   input  logic [4:0]       WriteRegW,
   input  logic             RegWriteE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             MemtoRegE,
   input  logic             MemtoRegM,
   input  logic             BranchD,
   input  logic             halt_req,
   input  logic             step_req,
   input  logic             resume,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushE,
   output logic             ForwardAD,
   output logic             ForwardBD,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int DLOAD = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
   localparam int DCW   = $clog2(DLOAD + 1);

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      HALT,
      STEP
   } state_t;

   state_t         state;
   logic [DCW-1:0] drainCnt;
   logic           forceStall;
   logic           lwStall;
   logic           brStall;
   logic           hz;

   function automatic logic [1:0] fwdSel(
      input logic [4:0] src,
      input logic       rwM,
      input logic [4:0] wrM,
      input logic       rwW,
      input logic [4:0] wrW
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (src != 5'd0 && rwM && wrM == src) begin
         sel = 2'b10;
      end else if (src != 5'd0 && rwW && wrW == src) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   assign ForwardAE = fwdSel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
   assign ForwardBE = fwdSel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
   assign ForwardAD = (RsD != 5'd0) && RegWriteM && (WriteRegM == RsD);
   assign ForwardBD = (RtD != 5'd0) && RegWriteM && (WriteRegM == RtD);

   assign lwStall = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
   assign brStall = BranchD &&
      ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
       (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));
   assign hz = lwStall | brStall;

   // DRAIN/HALT force a bubble regardless of hz; RUN/STEP pass hz through.
   assign StallF = forceStall | hz;
   assign StallD = forceStall | hz;
   assign FlushE = forceStall | hz;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= RUN;
         drainCnt   <= '0;
         forceStall <= 1'b0;
         halted     <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (halt_req) begin
                  state      <= DRAIN;
                  drainCnt   <= DCW'(DLOAD);
                  forceStall <= 1'b1;
               end
            end
            DRAIN: begin
               drainCnt <= drainCnt - DCW'(1);
               if (drainCnt <= DCW'(1)) begin
                  state  <= HALT;
                  halted <= 1'b1;
               end
            end
            HALT: begin
               if (resume) begin
                  state      <= RUN;
                  forceStall <= 1'b0;
                  halted     <= 1'b0;
               end else if (step_req) begin
                  state      <= STEP;
                  forceStall <= 1'b0;
                  halted     <= 1'b0;
               end
            end
            STEP: begin
               // Leave only once the stepped instruction actually advances.
               if (!hz) begin
                  state      <= DRAIN;
                  drainCnt   <= DCW'(DLOAD);
                  forceStall <= 1'b1;
               end
            end
            default: begin
               state      <= RUN;
               drainCnt   <= '0;
               forceStall <= 1'b0;
               halted     <= 1'b0;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] perfCnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         perfCnt <= '0;
      end else if (hz && (state == RUN || state == STEP) && perfCnt != '1) begin
         perfCnt <= perfCnt + CNT_W'(1);
      end
   end

   assign stall_cnt = perfCnt;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_run_ctrl.sv
// Self-checking bench for hazard_run_ctrl.
// Vector table for the combinational paths, sequences for run control.
module tb_hazard_run_ctrl;

   typedef struct {
      logic       rst, hreq, sreq, res;
      logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
      logic       rwE, rwM, rwW, m2rE, m2rM, brD;
   } in_t;

   typedef struct {
      logic        stall, fAD, fBD;
      logic [1:0]  fAE, fBE;
      logic        hlt;
      logic        chkCnt;
      logic [15:0] cnt;
   } exp_t;

   typedef struct {
      string name;
      in_t   i;
      exp_t  e;
   } vec_t;

`ifdef HAZARD_PERF_CNT_EN
   localparam logic [15:0] CNT10 = 16'd10;
`else
   localparam logic [15:0] CNT10 = 16'd0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
   logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD;
   logic        halt_req, step_req, resume;
   logic        StallF, StallD, FlushE, ForwardAD, ForwardBD, halted;
   logic [1:0]  ForwardAE, ForwardBE;
   logic [15:0] stall_cnt;

   int errors = 0;
   int checks = 0;
   exp_t  expQ[$];
   string nameQ[$];
   vec_t  tbl[13];

   always #5 clk = ~clk;

   hazard_run_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
      .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
      .halt_req(halt_req), .step_req(step_req), .resume(resume),
      .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .halted(halted), .stall_cnt(stall_cnt)
   );

   function automatic in_t mkIn(
      input logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW,
      input logic rwE, rwM, rwW, m2rE, m2rM, brD
   );
      in_t r;
      r.rst = 1'b1; r.hreq = 1'b0; r.sreq = 1'b0; r.res = 1'b0;
      r.rsD = rsD; r.rtD = rtD; r.rsE = rsE; r.rtE = rtE;
      r.wrE = wrE; r.wrM = wrM; r.wrW = wrW;
      r.rwE = rwE; r.rwM = rwM; r.rwW = rwW;
      r.m2rE = m2rE; r.m2rM = m2rM; r.brD = brD;
      return r;
   endfunction

   function automatic in_t ctl(input in_t b, input logic h, s, r);
      in_t o;
      o = b; o.hreq = h; o.sreq = s; o.res = r;
      return o;
   endfunction

   function automatic exp_t mkExp(
      input logic st, ad, bd, input logic [1:0] ae, be, input logic h
   );
      exp_t e;
      e.stall = st; e.fAD = ad; e.fBD = bd; e.fAE = ae; e.fBE = be;
      e.hlt = h; e.chkCnt = 1'b0; e.cnt = 16'd0;
      return e;
   endfunction

   function automatic exp_t withCnt(input exp_t b, input logic [15:0] c);
      exp_t e;
      e = b; e.chkCnt = 1'b1; e.cnt = c;
      return e;
   endfunction

   task automatic drive(input in_t i);
      rst = i.rst; halt_req = i.hreq; step_req = i.sreq; resume = i.res;
      RsD = i.rsD; RtD = i.rtD; RsE = i.rsE; RtE = i.rtE;
      WriteRegE = i.wrE; WriteRegM = i.wrM; WriteRegW = i.wrW;
      RegWriteE = i.rwE; RegWriteM = i.rwM; RegWriteW = i.rwW;
      MemtoRegE = i.m2rE; MemtoRegM = i.m2rM; BranchD = i.brD;
   endtask

   task automatic checkOut();
      exp_t  e;
      string n;
      logic  bad;
      e = expQ.pop_front();
      n = nameQ.pop_front();
      checks++;
      bad = (StallF !== e.stall) || (StallD !== e.stall) ||
            (FlushE !== e.stall) || (ForwardAD !== e.fAD) ||
            (ForwardBD !== e.fBD) || (ForwardAE !== e.fAE) ||
            (ForwardBE !== e.fBE) || (halted !== e.hlt) ||
            (e.chkCnt && stall_cnt !== e.cnt);
      if (bad) begin
         errors++;
         $display("FAIL %s: got stall=%b%b%b fAD=%b fBD=%b fAE=%b fBE=%b halted=%b cnt=%0d, want stall=%b fAD=%b fBD=%b fAE=%b fBE=%b halted=%b cnt=%0d(chk=%b)",
                  n, StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE,
                  ForwardBE, halted, stall_cnt, e.stall, e.fAD, e.fBD, e.fAE,
                  e.fBE, e.hlt, e.cnt, e.chkCnt);
      end
   endtask

   // One cycle: drive after the edge, queue expectation, compare on negedge.
   task automatic cyc(input in_t i, input exp_t e, input string n);
      @(posedge clk);
      #1;
      drive(i);
      expQ.push_back(e);
      nameQ.push_back(n);
      @(negedge clk);
      checkOut();
   endtask

   initial begin
      in_t idle, lu, rstIn;
      idle  = mkIn(0,0,0,0,0,0,0, 0,0,0,0,0,0);
      lu    = mkIn(8,0,0,8,0,0,0, 0,0,0,1,0,0);
      rstIn = idle;
      rstIn.rst = 1'b0;

      tbl[0]  = '{"fwdM",       mkIn(0,0,5,0,0,5,5, 0,1,1,0,0,0), mkExp(0,0,0,2'b10,2'b00,0)};
      tbl[1]  = '{"fwdZero",    mkIn(0,0,0,0,0,5,5, 0,1,1,0,0,0), mkExp(0,0,0,2'b00,2'b00,0)};
      tbl[2]  = '{"fwdW",       mkIn(0,0,7,0,0,7,7, 0,0,1,0,0,0), mkExp(0,0,0,2'b01,2'b00,0)};
      tbl[3]  = '{"fwdBM",      mkIn(0,0,0,9,0,9,9, 0,1,1,0,0,0), mkExp(0,0,0,2'b00,2'b10,0)};
      tbl[4]  = '{"fwdBnone",   mkIn(0,0,0,9,0,9,9, 0,0,0,0,0,0), mkExp(0,0,0,2'b00,2'b00,0)};
      tbl[5]  = '{"loadUse",    mkIn(8,0,0,8,0,0,0, 0,0,0,1,0,0), mkExp(1,0,0,2'b00,2'b00,0)};
      tbl[6]  = '{"loadDrop",   mkIn(8,0,0,8,0,0,0, 0,0,0,0,0,0), mkExp(0,0,0,2'b00,2'b00,0)};
      tbl[7]  = '{"loadUseRt",  mkIn(0,4,0,4,0,0,0, 0,0,0,1,0,0), mkExp(1,0,0,2'b00,2'b00,0)};
      tbl[8]  = '{"branchE",    mkIn(0,3,0,0,3,0,0, 1,0,0,0,0,1), mkExp(1,0,0,2'b00,2'b00,0)};
      tbl[9]  = '{"branchM",    mkIn(0,3,0,0,0,3,0, 0,1,0,0,0,1), mkExp(0,0,1,2'b00,2'b00,0)};
      tbl[10] = '{"branchLdM",  mkIn(6,0,0,0,0,6,0, 0,1,0,0,1,1), mkExp(1,1,0,2'b00,2'b00,0)};
      tbl[11] = '{"fwdDzero",   mkIn(0,0,0,0,0,0,0, 0,1,0,0,0,0), mkExp(0,0,0,2'b00,2'b00,0)};
      tbl[12] = '{"branchNoWr", mkIn(3,0,0,0,3,0,0, 0,0,0,0,0,1), mkExp(0,0,0,2'b00,2'b00,0)};

      drive(rstIn);
      @(posedge clk);
      @(posedge clk);
      cyc(idle, withCnt(mkExp(0,0,0,0,0,0), 16'd0), "resetState");

      foreach (tbl[k]) cyc(tbl[k].i, tbl[k].e, tbl[k].name);

      // Halt, drain, resume (resume wins over a simultaneous step).
      cyc(ctl(idle,1,0,0), mkExp(0,0,0,0,0,0), "haltPulse");
      for (int k = 0; k < 3; k++) cyc(idle, mkExp(1,0,0,0,0,0), "drain");
      cyc(idle, mkExp(1,0,0,0,0,1), "halted");
      cyc(lu, mkExp(1,0,0,0,0,1), "haltHold");
      cyc(ctl(idle,0,1,1), mkExp(1,0,0,0,0,1), "resumeReq");
      cyc(idle, mkExp(0,0,0,0,0,0), "runAfterResume");
      cyc(idle, mkExp(0,0,0,0,0,0), "runStays");

      // Single step without a hazard.
      cyc(ctl(idle,1,0,0), mkExp(0,0,0,0,0,0), "haltPulse2");
      for (int k = 0; k < 3; k++) cyc(idle, mkExp(1,0,0,0,0,0), "drain2");
      cyc(idle, mkExp(1,0,0,0,0,1), "halted2");
      cyc(ctl(idle,0,1,0), mkExp(1,0,0,0,0,1), "stepReq");
      cyc(idle, mkExp(0,0,0,0,0,0), "stepExec");
      for (int k = 0; k < 3; k++) cyc(idle, mkExp(1,0,0,0,0,0), "stepDrain");
      cyc(idle, mkExp(1,0,0,0,0,1), "stepHalted");

      // Single step held by a load-use hazard.
      cyc(ctl(idle,0,1,0), mkExp(1,0,0,0,0,1), "stepReqHz");
      cyc(lu, mkExp(1,0,0,0,0,0), "stepHeld1");
      cyc(lu, mkExp(1,0,0,0,0,0), "stepHeld2");
      cyc(idle, mkExp(0,0,0,0,0,0), "stepGo");
      for (int k = 0; k < 3; k++) cyc(idle, mkExp(1,0,0,0,0,0), "stepHzDrain");
      cyc(idle, mkExp(1,0,0,0,0,1), "stepHzHalted");
      cyc(ctl(idle,0,0,1), mkExp(1,0,0,0,0,1), "resume2");

      // Halt coinciding with a hazard, then reset during drain.
      cyc(ctl(lu,1,0,0), mkExp(1,0,0,0,0,0), "haltWithHz");
      cyc(ctl(idle,0,0,1), mkExp(1,0,0,0,0,0), "drainIgnoresRes");
      cyc(rstIn, mkExp(1,0,0,0,0,0), "rstInDrain");
      cyc(idle, withCnt(mkExp(0,0,0,0,0,0), 16'd0), "afterRst");
      for (int k = 0; k < 10; k++) cyc(lu, mkExp(1,0,0,0,0,0), "cntStall");
      cyc(idle, withCnt(mkExp(0,0,0,0,0,0), CNT10), "stallCnt10");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
